// File: rtl/byte_packer_pkg.sv
// Shared types and helpers for the byte packer: FSM encoding, word geometry,
// and the keep-mask / zero-padding helpers used for partial words.
package byte_packer_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    OUT   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_SKID_DEPTH = 4;

  // Low n lanes valid; n=0 yields an empty mask.
  function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [IDX_W-1:0] n);
    logic [BYTES_PER_WORD:0] one_hot;
    one_hot   = (BYTES_PER_WORD+1)'(1) << n;
    keep_mask = BYTES_PER_WORD'(one_hot - (BYTES_PER_WORD+1)'(1));
  endfunction

  function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] w,
                                                 input logic [BYTES_PER_WORD-1:0] k);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      r[8*i +: 8] = k[i] ? w[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_skid_fifo.sv
// Small circular byte buffer that absorbs the upstream read latency.
// Simultaneous push and pop is accepted even when full.
module byte_skid_fifo #(
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PTR_W'(DEPTH - 1)) ? '0 : r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= (r_rd == PTR_W'(DEPTH - 1)) ? '0 : r_rd + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/byte_packer.sv
// Reads bytes from an upstream FIFO with fixed read latency, buffers them in a
// skid FIFO and packs them little-endian into 32-bit words on a valid/ready stream.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int SKID_DEPTH = DEF_SKID_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifo_empty,
  input  logic                      fifo_underflow,
  input  logic [7:0]                fifo_dout,
  output logic                      fifo_r_en,
  input  logic                      flush,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WORD_W-1:0]         m_data,
  output logic [BYTES_PER_WORD-1:0] m_keep,
  output logic                      err
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  logic                      r_fifo_r_en;
  logic [RD_LAT-1:0]         r_track;
  logic [CNT_W-1:0]          r_inflight;
  logic                      r_err;
  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IDX_W-1:0]          r_byte_idx;
  logic [WORD_W-1:0]         r_asm;
  logic [WORD_W-1:0]         w_asm_nxt;
  logic                      r_asm_full;
  logic                      r_drain_out;
  logic                      r_flush_pend;
  logic                      r_m_valid;
  logic [WORD_W-1:0]         r_m_data;
  logic [BYTES_PER_WORD-1:0] r_m_keep;

  logic                      w_cap;
  logic                      w_push;
  logic                      w_pop;
  logic [7:0]                w_skid_dout;
  logic [CNT_W-1:0]          w_skid_count;
  logic                      w_skid_full;
  logic                      w_skid_empty;
  logic [CNT_W:0]            w_occ;
  logic                      w_issue;
  logic                      w_hs;
  logic                      w_complete;
  logic                      w_idle;

  logic                      w_ld;
  logic [WORD_W-1:0]         w_ld_data;
  logic [BYTES_PER_WORD-1:0] w_ld_keep;
  logic                      w_set_full;
  logic                      w_clr_full;
  logic                      w_part;
  logic                      w_pend_clr;

  assign fifo_r_en = r_fifo_r_en;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_keep    = r_m_keep;
  assign err       = r_err;

  // Read issue and latency tracking: the request on the wire counts as occupancy,
  // and a pop this cycle frees a slot, so reads never outrun the skid buffer.
  assign w_cap  = r_track[RD_LAT-1];
  assign w_push = w_cap && !fifo_underflow;
  assign w_occ  = {1'b0, r_inflight} + (CNT_W+1)'(r_fifo_r_en)
                + {1'b0, w_skid_count} - (CNT_W+1)'(w_pop);
  assign w_issue = !fifo_empty && !r_flush_pend && !w_skid_full
                && (w_occ < (CNT_W+1)'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_r_en <= 1'b0;
      r_track     <= '0;
      r_inflight  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_fifo_r_en <= w_issue;
      r_track     <= RD_LAT'({r_track, r_fifo_r_en});
      case ({r_fifo_r_en, w_cap})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_cap && fifo_underflow) r_err <= 1'b1;
    end
  end

  byte_skid_fifo #(.DEPTH(SKID_DEPTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (fifo_dout),
    .pop   (w_pop),
    .dout  (w_skid_dout),
    .count (w_skid_count),
    .full  (w_skid_full),
    .empty (w_skid_empty)
  );

  // Packing stage: one byte per cycle into the assembly register unless a
  // completed word is already parked there waiting for the output slot.
  assign w_pop      = !w_skid_empty && !r_asm_full;
  assign w_complete = w_pop && (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));
  assign w_hs       = r_m_valid && m_ready;
  assign w_idle     = (r_inflight == '0) && !r_fifo_r_en && w_skid_empty;

  always_comb begin
    w_asm_nxt = r_asm;
    w_asm_nxt[8*r_byte_idx +: 8] = w_skid_dout;
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_asm <= w_asm_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL: begin
        if (r_asm_full || w_complete) w_state_nxt = OUT;
        else if (r_flush_pend)        w_state_nxt = DRAIN;
      end
      OUT: begin
        if (w_hs) w_state_nxt = FILL;
      end
      DRAIN: begin
        if (w_complete)  w_state_nxt = OUT;
        else if (w_idle) w_state_nxt = (r_byte_idx == '0) ? FILL : OUT;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    w_ld       = 1'b0;
    w_ld_data  = '0;
    w_ld_keep  = '0;
    w_set_full = 1'b0;
    w_clr_full = 1'b0;
    w_part     = 1'b0;
    w_pend_clr = 1'b0;
    case (r_state)
      FILL: begin
        if (r_asm_full) begin
          w_ld       = 1'b1;
          w_ld_data  = r_asm;
          w_ld_keep  = '1;
          w_clr_full = 1'b1;
        end else if (w_complete) begin
          w_ld      = 1'b1;
          w_ld_data = w_asm_nxt;
          w_ld_keep = '1;
        end
      end
      OUT: begin
        if (w_complete)         w_set_full = 1'b1;
        if (w_hs && r_drain_out) w_pend_clr = 1'b1;
      end
      DRAIN: begin
        if (w_complete) begin
          w_ld      = 1'b1;
          w_ld_data = w_asm_nxt;
          w_ld_keep = '1;
        end else if (w_idle) begin
          if (r_byte_idx == '0) begin
            w_pend_clr = 1'b1;
          end else begin
            w_ld      = 1'b1;
            w_ld_keep = keep_mask(r_byte_idx);
            w_ld_data = pad_word(r_asm, keep_mask(r_byte_idx));
            w_part    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output register and packing/flush control.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_keep     <= '0;
      r_byte_idx   <= '0;
      r_asm_full   <= 1'b0;
      r_drain_out  <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_ld) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_ld_data;
        r_m_keep  <= w_ld_keep;
      end else if (w_hs) begin
        r_m_valid <= 1'b0;
      end
      if (w_part)     r_byte_idx <= '0;
      else if (w_pop) r_byte_idx <= r_byte_idx + IDX_W'(1);
      if (w_set_full)      r_asm_full <= 1'b1;
      else if (w_clr_full) r_asm_full <= 1'b0;
      if (w_part)    r_drain_out <= 1'b1;
      else if (w_hs) r_drain_out <= 1'b0;
      if (w_pend_clr)  r_flush_pend <= 1'b0;
      else if (flush)  r_flush_pend <= 1'b1;
    end
  end

endmodule
